// File: rtl/pic_bus_initiator_pkg.sv
// Shared types and constants for the 8259A host-side bus initiator.
// Holds the phase FSM encoding, phase-counter width and timing-parameter limits.
package pic_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } pic_bus_state_t;

   localparam int PHASE_CNT_W = 5;
   localparam int PARAM_MIN   = 1;
   localparam int PARAM_MAX   = 16;

endpackage

// File: rtl/pic_bus_initiator_strobe_timer.sv
// Loadable down-counter that times the SETUP/STROBE/HOLD phases.
// done is high while the count sits at zero, i.e. in the last cycle of a phase.
module pic_strobe_timer
   import pic_bus_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic [PHASE_CNT_W-1:0] load_value,
   output logic                   done
);

   logic [PHASE_CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/pic_bus_initiator.sv
// Host-side CPU-bus initiator for the 8259A PIC: one request -> one timed bus cycle.
// Optional interrupt-acknowledge cycles are enabled by defining PIC_INTA_CYCLE_EN.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// SETUP  | CS_bar/A0/data valid ahead of the strobe (also the INTA inter-pulse gap)
// STROBE | RD_bar, WR_bar or INTA_bar low; read data captured on the last edge
// HOLD   | address/data held after the strobe rises (also the INTA inter-pulse gap)
module pic_bus_initiator
   import pic_bus_pkg::*;
#(
   parameter int SETUP_CYCLES = 1,
   parameter int PULSE_CYCLES = 2,
   parameter int HOLD_CYCLES  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic       req_a0,
   input  logic [7:0] req_data,
   input  logic       req_inta,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       CS_bar,
   output logic       RD_bar,
   output logic       WR_bar,
   output logic       INTA_bar,
   output logic       A0,
   output logic [7:0] data_bus_out,
   output logic       data_bus_oe,
   input  logic [7:0] data_bus_in
);

   if (SETUP_CYCLES < PARAM_MIN || SETUP_CYCLES > PARAM_MAX ||
       PULSE_CYCLES < PARAM_MIN || PULSE_CYCLES > PARAM_MAX ||
       HOLD_CYCLES  < PARAM_MIN || HOLD_CYCLES  > PARAM_MAX) begin : g_param_check
      $error("pic_bus_initiator: SETUP/PULSE/HOLD_CYCLES must be within 1..16");
   end

   // Counter runs N-1 .. 0, so a phase lasts exactly N cycles.
   localparam logic [PHASE_CNT_W-1:0] SETUP_LOAD = PHASE_CNT_W'(SETUP_CYCLES - 1);
   localparam logic [PHASE_CNT_W-1:0] PULSE_LOAD = PHASE_CNT_W'(PULSE_CYCLES - 1);
   localparam logic [PHASE_CNT_W-1:0] HOLD_LOAD  = PHASE_CNT_W'(HOLD_CYCLES - 1);

   pic_bus_state_t         state, state_next;
   logic                   second, second_next;
   logic                   lat_write, lat_inta, lat_a0;
   logic [7:0]             lat_data;
   logic                   inta_sel;
   logic                   accept;
   logic                   t_load, t_done;
   logic [PHASE_CNT_W-1:0] t_value;
   logic                   capture, finish;
   logic                   cur_write, cur_inta, cur_a0;
   logic [7:0]             cur_data;
   logic                   busy_next, strobe_next;
   logic                   d_cs, d_rd, d_wr, d_inta, d_a0, d_oe;
   logic [7:0]             d_dout;

`ifdef PIC_INTA_CYCLE_EN
   assign inta_sel = req_inta;
`else
   logic unused_inta;
   assign inta_sel    = 1'b0;
   assign unused_inta = req_inta;
`endif

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && (state == IDLE);

   pic_strobe_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (t_load),
      .load_value (t_value),
      .done       (t_done)
   );

   always_comb begin
      state_next  = state;
      second_next = second;
      t_load      = 1'b0;
      t_value     = '0;
      capture     = 1'b0;
      finish      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next  = SETUP;
               second_next = 1'b0;
               t_load      = 1'b1;
               t_value     = SETUP_LOAD;
            end
         end
         SETUP: begin
            if (t_done) begin
               state_next = STROBE;
               t_load     = 1'b1;
               t_value    = PULSE_LOAD;
            end
         end
         STROBE: begin
            if (t_done) begin
               state_next = HOLD;
               t_load     = 1'b1;
               t_value    = HOLD_LOAD;
               // INTA vector is only valid on the second pulse.
               capture    = !lat_write && (!lat_inta || second);
            end
         end
         HOLD: begin
            if (t_done) begin
               if (lat_inta && !second) begin
                  state_next  = SETUP;
                  second_next = 1'b1;
                  t_load      = 1'b1;
                  t_value     = SETUP_LOAD;
               end else begin
                  state_next = IDLE;
                  finish     = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Bus outputs are decoded from the next state so they can be registered.
   always_comb begin
      cur_write   = accept ? (req_write && !inta_sel) : lat_write;
      cur_inta    = accept ? inta_sel : lat_inta;
      cur_a0      = accept ? req_a0 : lat_a0;
      cur_data    = accept ? req_data : lat_data;
      busy_next   = (state_next != IDLE);
      strobe_next = (state_next == STROBE);
      d_cs        = !(busy_next && !cur_inta);
      d_wr        = !(strobe_next && cur_write);
      d_rd        = !(strobe_next && !cur_write && !cur_inta);
      d_inta      = !(strobe_next && cur_inta);
      d_a0        = busy_next && !cur_inta && cur_a0;
      d_oe        = busy_next && cur_write;
      d_dout      = d_oe ? cur_data : 8'h00;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         second    <= 1'b0;
         lat_write <= 1'b0;
         lat_inta  <= 1'b0;
         lat_a0    <= 1'b0;
         lat_data  <= 8'h00;
      end else begin
         state  <= state_next;
         second <= second_next;
         if (accept) begin
            lat_write <= req_write && !inta_sel;
            lat_inta  <= inta_sel;
            lat_a0    <= req_a0;
            lat_data  <= req_data;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         CS_bar       <= 1'b1;
         RD_bar       <= 1'b1;
         WR_bar       <= 1'b1;
         INTA_bar     <= 1'b1;
         A0           <= 1'b0;
         data_bus_out <= 8'h00;
         data_bus_oe  <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_data     <= 8'h00;
      end else begin
         CS_bar       <= d_cs;
         RD_bar       <= d_rd;
         WR_bar       <= d_wr;
         INTA_bar     <= d_inta;
         A0           <= d_a0;
         data_bus_out <= d_dout;
         data_bus_oe  <= d_oe;
         rsp_valid    <= finish;
         if (capture) begin
            rsp_data <= data_bus_in;
         end
      end
   end

endmodule

// File: tb/tb_pic_bus_initiator.sv
// Self-checking bench for pic_bus_initiator: directed bus-cycle patterns plus
// randomized traffic checked each cycle against a phase-window reference model.
module tb_pic_bus_initiator;

   localparam int S = 1;
   localparam int P = 2;
   localparam int H = 1;
`ifdef PIC_INTA_CYCLE_EN
   localparam bit INTA_EN = 1'b1;
`else
   localparam bit INTA_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req_valid = 1'b0, req_write = 1'b0, req_a0 = 1'b0, req_inta = 1'b0;
   logic [7:0] req_data = 8'h00, data_bus_in = 8'h00;
   logic       req_ready, rsp_valid, CS_bar, RD_bar, WR_bar, INTA_bar, A0, data_bus_oe;
   logic [7:0] rsp_data, data_bus_out;

   pic_bus_initiator #(.SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_a0(req_a0), .req_data(req_data), .req_inta(req_inta),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .CS_bar(CS_bar), .RD_bar(RD_bar),
      .WR_bar(WR_bar), .INTA_bar(INTA_bar), .A0(A0), .data_bus_out(data_bus_out),
      .data_bus_oe(data_bus_oe), .data_bus_in(data_bus_in)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: kind 0 = read, 1 = write, 2 = INTA; k = cycles since accept edge.
   int         cyc = 0;
   bit         mvalid = 1'b0;
   int         t0 = 0;
   int         mkind = 0;
   logic       ma0 = 1'b0;
   logic [7:0] mdata = 8'h00;
   logic [7:0] exp_rsp = 8'h00;
   int         acc_count = 0;

   function automatic int tx_len(input int kind);
      return (kind == 2) ? 2 * (S + P + H) : (S + P + H);
   endfunction

   function automatic int cap_k(input int kind);
      return (kind == 2) ? (2 * S + 2 * P + H) : (S + P);
   endfunction

   function automatic bit model_ready(input int c);
      return !mvalid || ((c - t0) >= tx_len(mkind) + 1);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mvalid  <= 1'b0;
         exp_rsp <= 8'h00;
      end else begin
         if (mvalid && (cyc - t0) == cap_k(mkind) && mkind != 1)
            exp_rsp <= data_bus_in;
         if (req_valid && model_ready(cyc)) begin
            mvalid    <= 1'b1;
            t0        <= cyc;
            mkind     <= (INTA_EN && req_inta) ? 2 : (req_write ? 1 : 0);
            ma0       <= req_a0;
            mdata     <= req_data;
            acc_count <= acc_count + 1;
         end
      end
   end

   always @(negedge clk) begin : cmp_proc
      int k;
      int len;
      bit act;
      bit stb;
      k   = cyc - t0;
      len = tx_len(mkind);
      act = mvalid && k >= 1 && k <= len;
      stb = act && ((k >= S + 1 && k <= S + P) ||
                    (mkind == 2 && k >= 2 * S + P + H + 1 && k <= 2 * S + 2 * P + H));
      if (chk_en) begin
         chk("cs_bar", CS_bar, !(act && mkind != 2));
         chk("wr_bar", WR_bar, !(stb && mkind == 1));
         chk("rd_bar", RD_bar, !(stb && mkind == 0));
         chk("inta_bar", INTA_bar, !(stb && mkind == 2));
         chk("data_bus_oe", data_bus_oe, act && mkind == 1);
         chk("rsp_valid", rsp_valid, mvalid && k == len + 1);
         chk("rsp_data", rsp_data, exp_rsp);
         chk("req_ready", req_ready, model_ready(cyc));
         if (act && mkind != 2) chk("a0", A0, ma0);
         if (act && mkind == 1) chk("data_bus_out", data_bus_out, mdata);
      end
   end

   // Issue one request from idle and record ten cycles of bus activity (bit k = cycle k).
   task automatic issue_sample(input logic wr, input logic inta, input logic a0, input logic [7:0] d,
                               output logic [10:0] cs_v, output logic [10:0] wr_v,
                               output logic [10:0] rd_v, output logic [10:0] it_v,
                               output logic [10:0] oe_v, output logic [10:0] rv_v,
                               output logic [7:0] rdat);
      cs_v = '1; wr_v = '1; rd_v = '1; it_v = '1; oe_v = '0; rv_v = '0; rdat = 8'h00;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_inta = inta; req_a0 = a0; req_data = d;
      @(negedge clk);
      req_valid = 1'b0; req_inta = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (k > 1) @(negedge clk);
         cs_v[k] = CS_bar; wr_v[k] = WR_bar; rd_v[k] = RD_bar;
         it_v[k] = INTA_bar; oe_v[k] = data_bus_oe; rv_v[k] = rsp_valid;
         if (rsp_valid) rdat = rsp_data;
      end
   endtask

   task automatic run_random(input int ntx);
      int  done_tx = 0;
      int  gap = 0;
      int  wait_cnt = 0;
      int  base = 0;
      bit  pending = 1'b0;
      while (done_tx < ntx) begin
         @(negedge clk);
         data_bus_in = 8'($urandom);
         if (pending && acc_count != base) begin
            pending = 1'b0; done_tx++; req_valid = 1'b0;
            gap = $urandom_range(0, 3);
         end else if (pending) begin
            wait_cnt++;
            if (wait_cnt > 60) begin
               checks++; errors++;
               $display("FAIL accept_timeout actual=not_accepted required=accepted at %0t", $time);
               pending = 1'b0; req_valid = 1'b0; done_tx = ntx;
            end
         end
         if (!pending && done_tx < ntx) begin
            if (gap > 0) gap--;
            else begin
               req_valid = 1'b1;
               req_write = 1'($urandom);
               req_a0    = 1'($urandom);
               req_data  = 8'($urandom);
               req_inta  = ($urandom_range(0, 3) == 0);
               pending   = 1'b1; base = acc_count; wait_cnt = 0;
            end
         end
      end
      @(negedge clk);
      req_valid = 1'b0; req_inta = 1'b0;
      repeat (15) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [10:0] cs_v, wr_v, rd_v, it_v, oe_v, rv_v;
      logic [7:0]  rdat;
      logic [19:0] cs_b, rv_b;
      logic [7:0]  b2b_data [4];
      logic        b2b_a0 [4];
      int          idx, base, nrsp;

      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs", CS_bar, 1); chk("rst_rd", RD_bar, 1); chk("rst_wr", WR_bar, 1);
      chk("rst_inta", INTA_bar, 1); chk("rst_a0", A0, 0); chk("rst_dout", data_bus_out, 8'h00);
      chk("rst_oe", data_bus_oe, 0); chk("rst_rspv", rsp_valid, 0); chk("rst_rspd", rsp_data, 8'h00);
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", req_ready, 1);
      chk_en = 1'b1;

      // ICW1 write
      issue_sample(1'b1, 1'b0, 1'b0, 8'h11, cs_v, wr_v, rd_v, it_v, oe_v, rv_v, rdat);
      chk("icw1_cs", cs_v, 11'b11111100001);
      chk("icw1_wr", wr_v, 11'b11111110011);
      chk("icw1_rd", rd_v, 11'h7FF);
      chk("icw1_oe", oe_v, 11'b00000011110);
      chk("icw1_rsp", rv_v, 11'b00000100000);

      // IMR read
      data_bus_in = 8'hA5;
      issue_sample(1'b0, 1'b0, 1'b1, 8'h00, cs_v, wr_v, rd_v, it_v, oe_v, rv_v, rdat);
      chk("imr_rd", rd_v, 11'b11111110011);
      chk("imr_wr", wr_v, 11'h7FF);
      chk("imr_oe", oe_v, 11'h000);
      chk("imr_rsp", rv_v, 11'b00000100000);
      chk("imr_data", rdat, 8'hA5);

      // Back-to-back ICW1..ICW4 with req_valid held high
      b2b_data = '{8'h11, 8'h20, 8'h04, 8'h01};
      b2b_a0   = '{1'b0, 1'b1, 1'b1, 1'b1};
      @(negedge clk);
      base = acc_count;
      req_valid = 1'b1; req_write = 1'b1; req_a0 = b2b_a0[0]; req_data = b2b_data[0];
      idx = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (acc_count - base == idx) begin
            if (idx < 4) begin
               req_a0 = b2b_a0[idx]; req_data = b2b_data[idx];
            end else req_valid = 1'b0;
            idx++;
         end
         cs_b[k] = CS_bar; rv_b[k] = rsp_valid;
      end
      req_valid = 1'b0;
      chk("b2b_cs_gaps", cs_b, 20'h84210);
      chk("b2b_rsp", rv_b, 20'h84210);
      chk("b2b_accepts", acc_count - base, 4);

      // Reset during the STROBE of a write
      repeat (3) @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_a0 = 1'b1; req_data = 8'h5A;
      @(negedge clk) req_valid = 1'b0;
      @(posedge clk);
      #2;
      chk("abort_wr_low", WR_bar, 0);
      reset = 1'b1;
      #1;
      chk("abort_wr", WR_bar, 1); chk("abort_cs", CS_bar, 1); chk("abort_oe", data_bus_oe, 0);
      @(negedge clk);
      @(negedge clk) reset = 1'b0;
      nrsp = 0;
      repeat (8) begin
         @(negedge clk);
         nrsp += int'(rsp_valid);
      end
      chk("abort_no_rsp", nrsp, 0);
      issue_sample(1'b1, 1'b0, 1'b0, 8'h3C, cs_v, wr_v, rd_v, it_v, oe_v, rv_v, rdat);
      chk("post_abort_cs", cs_v, 11'b11111100001);
      chk("post_abort_wr", wr_v, 11'b11111110011);
      chk("post_abort_rsp", rv_v, 11'b00000100000);

      // Interrupt acknowledge
      data_bus_in = 8'h21;
      issue_sample(1'b0, 1'b1, 1'b0, 8'h00, cs_v, wr_v, rd_v, it_v, oe_v, rv_v, rdat);
      chk("inta_oe", oe_v, 11'h000);
      chk("inta_vector", rdat, 8'h21);
`ifdef PIC_INTA_CYCLE_EN
      chk("inta_pulses", it_v, 11'b11100110011);
      chk("inta_cs", cs_v, 11'h7FF);
      chk("inta_rd", rd_v, 11'h7FF);
      chk("inta_rsp", rv_v, 11'b01000000000);
`else
      chk("inta_pulses", it_v, 11'h7FF);
      chk("inta_cs", cs_v, 11'b11111100001);
      chk("inta_rd", rd_v, 11'b11111110011);
      chk("inta_rsp", rv_v, 11'b00000100000);
`endif

      repeat (4) @(negedge clk);
      run_random(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
